// File: rtl/nphase_pkg.sv
// Shared definitions for the N-phase generator: phase-count limits, step width
// and the ideal phase decode.
package nphase_pkg;

    localparam int PHASES_MIN = 2;
    localparam int PHASES_MAX = 8;

    typedef enum logic [1:0] {
        CELL_START,
        CELL_DEAD,
        CELL_DRIVE
    } cell_state_t;

    function automatic int step_width(input int phases);
        return $clog2(2 * phases);
    endfunction

    // Phase k is high for the N steps starting at step 2k (mod 2N).
    function automatic logic phase_level(input int step, input int k, input int n);
        int d;
        d = (step - 2 * k) % (2 * n);
        if (d < 0) begin
            d = d + 2 * n;
        end
        return (d < n);
    endfunction

endpackage

// File: rtl/nphase_deadtime.sv
// Complementary high/low drive for one phase with a programmable dead gap
// inserted after every change of the ideal level.
module nphase_deadtime
    import nphase_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            se,
    input  logic            rst_n,
    input  logic            q,
    input  logic [DT_W-1:0] dt,
    output logic            h,
    output logic            l
);

    cell_state_t     state_reg, state_next;
    logic [DT_W-1:0] cnt_reg, cnt_next;
    logic            q_last_reg, q_last_next;
    logic            h_reg, h_next;
    logic            l_reg, l_next;

    always_ff @(posedge se or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= CELL_START;
            cnt_reg    <= '0;
            q_last_reg <= 1'b0;
            h_reg      <= 1'b0;
            l_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            q_last_reg <= q_last_next;
            h_reg      <= h_next;
            l_reg      <= l_next;
        end
    end

    // CELL_START forces the first edge after reset to behave like a level change.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        q_last_next = q_last_reg;
        h_next      = h_reg;
        l_next      = l_reg;
        if (state_reg == CELL_START || q != q_last_reg) begin
            q_last_next = q;
            if (dt == '0) begin
                state_next = CELL_DRIVE;
                h_next     = q;
                l_next     = ~q;
            end else begin
                state_next = CELL_DEAD;
                cnt_next   = dt - DT_W'(1);
                h_next     = 1'b0;
                l_next     = 1'b0;
            end
        end else if (state_reg == CELL_DEAD) begin
            if (cnt_reg == '0) begin
                state_next = CELL_DRIVE;
                h_next     = q_last_reg;
                l_next     = ~q_last_reg;
            end else begin
                cnt_next = cnt_reg - DT_W'(1);
            end
        end
    end

    assign h = h_reg;
    assign l = l_reg;

endmodule

// File: rtl/nphase_gen.sv
// N-phase square-wave generator: prescaler, bidirectional step counter, phase
// decode, step/sync strobes and one dead-time cell per phase.
module nphase_gen
    import nphase_pkg::*;
#(
    parameter  int PHASES = 3,
    parameter  int DIV_W  = 16,
    parameter  int DT_W   = 8,
    localparam int SW     = step_width(PHASES)
) (
    input  logic              se,
    input  logic              rst_n,
    input  logic              en,
    input  logic              dir,
    input  logic [DIV_W-1:0]  div,
    input  logic [DT_W-1:0]   dt,
    output logic [SW-1:0]     step,
    output logic [PHASES-1:0] q,
    output logic [PHASES-1:0] h,
    output logic [PHASES-1:0] l,
    output logic              tick,
    output logic              sync
);

    localparam logic [SW-1:0] STEP_LAST = SW'(2 * PHASES - 1);

    generate
        if (PHASES < PHASES_MIN || PHASES > PHASES_MAX) begin : g_bad_phases
            $error("nphase_gen: PHASES out of range");
        end
    endgenerate

    logic [DIV_W-1:0] pc_reg, pc_next;
    logic [SW-1:0]    step_reg, step_next;
    logic             tick_reg, sync_reg;
    logic             advance;

    assign advance = en && (pc_reg == div);

    // PC simply increments when not matching, so a DIV lowered below PC wraps at all-ones.
    always_comb begin
        pc_next   = pc_reg;
        step_next = step_reg;
        if (en) begin
            pc_next = advance ? '0 : pc_reg + DIV_W'(1);
        end
        if (advance) begin
            if (dir) begin
                step_next = (step_reg == '0) ? STEP_LAST : step_reg - SW'(1);
            end else begin
                step_next = (step_reg == STEP_LAST) ? '0 : step_reg + SW'(1);
            end
        end
    end

    always_ff @(posedge se or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg   <= '0;
            step_reg <= '0;
            tick_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            pc_reg   <= pc_next;
            step_reg <= step_next;
            tick_reg <= advance;
            sync_reg <= advance && (step_next == '0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PHASES; gi++) begin : g_phase
            assign q[gi] = phase_level(int'(step_reg), gi, PHASES);

            nphase_deadtime #(
                .DT_W(DT_W)
            ) u_dt (
                .se   (se),
                .rst_n(rst_n),
                .q    (q[gi]),
                .dt   (dt),
                .h    (h[gi]),
                .l    (l[gi])
            );
        end
    endgenerate

    assign step = step_reg;
    assign tick = tick_reg;
    assign sync = sync_reg;

endmodule

// File: tb/tb_nphase_gen.sv
// Self-checking bench for nphase_gen: a 3-phase and a 4-phase instance share
// stimulus and are compared against a step/dead-time reference model.
module tb_nphase_gen;

    logic        se = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] div = '0;
    logic [7:0]  dt = '0;

    logic [2:0]  step3, q3, h3, l3;
    logic        tick3, sync3;
    logic [2:0]  step4;
    logic [3:0]  q4, h4, l4;
    logic        tick4, sync4;

    always #5 se = ~se;

    nphase_gen #(.PHASES(3), .DIV_W(16), .DT_W(8)) dut3 (
        .se(se), .rst_n(rst_n), .en(en), .dir(dir), .div(div), .dt(dt),
        .step(step3), .q(q3), .h(h3), .l(l3), .tick(tick3), .sync(sync3)
    );

    nphase_gen #(.PHASES(4), .DIV_W(16), .DT_W(8)) dut4 (
        .se(se), .rst_n(rst_n), .en(en), .dir(dir), .div(div), .dt(dt),
        .step(step4), .q(q4), .h(h4), .l(l4), .tick(tick4), .sync(sync4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: integer step/prescaler plus, per phase, the edge index of
    // the last sampled level change; a phase drives once DT edges have passed.
    int  nph[2] = '{3, 4};
    int  m_pc;
    int  m_step[2];
    bit  m_tick;
    bit  m_sync[2];
    bit  m_qprev[2][8];
    int  m_lastdet[2][8];
    int  m_edge = 0;
    bit  m_fresh;

    function automatic bit ref_level(input int s, input int k, input int n);
        return ((s - 2 * k + 8 * n) % (2 * n)) < n;
    endfunction

    function automatic int ref_q(input int d);
        int v = 0;
        for (int k = 0; k < nph[d]; k++)
            if (ref_level(m_step[d], k, nph[d])) v |= (1 << k);
        return v;
    endfunction

    function automatic int ref_drive(input int d, input bit high_side);
        int v = 0;
        if (!m_fresh)
            for (int k = 0; k < nph[d]; k++)
                if ((m_edge - m_lastdet[d][k]) >= int'(dt) && (m_qprev[d][k] == high_side))
                    v |= (1 << k);
        return v;
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_tick = 0;
        m_fresh = 1;
        for (int d = 0; d < 2; d++) begin
            m_step[d] = 0;
            m_sync[d] = 0;
        end
    endtask

    task automatic model_edge();
        bit adv;
        m_edge++;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < nph[d]; k++) begin
                bit qs = ref_level(m_step[d], k, nph[d]);
                if (m_fresh || qs != m_qprev[d][k]) m_lastdet[d][k] = m_edge;
                m_qprev[d][k] = qs;
            end
        m_fresh = 0;
        adv = en && (m_pc == int'(div));
        if (adv) begin
            m_pc = 0;
            for (int d = 0; d < 2; d++)
                m_step[d] = (m_step[d] + (dir ? 2 * nph[d] - 1 : 1)) % (2 * nph[d]);
        end else if (en) begin
            m_pc = (m_pc + 1) % 65536;
        end
        m_tick = adv;
        for (int d = 0; d < 2; d++) m_sync[d] = adv && (m_step[d] == 0);
    endtask

    task automatic check_model();
        chk("step3", step3, m_step[0]);
        chk("q3", q3, ref_q(0));
        chk("tick3", tick3, m_tick);
        chk("sync3", sync3, m_sync[0]);
        chk("h3", h3, ref_drive(0, 1'b1));
        chk("l3", l3, ref_drive(0, 1'b0));
        chk("hl3_overlap", h3 & l3, 0);
        chk("step4", step4, m_step[1]);
        chk("q4", q4, ref_q(1));
        chk("tick4", tick4, m_tick);
        chk("sync4", sync4, m_sync[1]);
        chk("h4", h4, ref_drive(1, 1'b1));
        chk("l4", l4, ref_drive(1, 1'b0));
        chk("hl4_overlap", h4 & l4, 0);
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge se);
        if (rst_n) model_edge();
        #1;
        check_model();
    endtask

    task automatic reset_dut(input int new_div, input int new_dt);
        rst_n = 1'b0;
        div = 16'(new_div);
        dt = 8'(new_dt);
        model_reset();
        #1;
        check_model();
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic       dir;
        logic [2:0] step;
        logic [2:0] q;
        logic       sync;
    } vec_t;

    vec_t tbl[10];

    initial begin : main
        int n, ticks, syncs, qhigh, last_tick, gap_bad, gaps, gap_len;
        bit seen_drive;
        logic [3:0] hist[$];
        int exp_rev[5];

        tbl[0] = '{1'b1, 1'b0, 3'd1, 3'b001, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 3'd2, 3'b011, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 3'd3, 3'b010, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 3'd4, 3'b110, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 3'd5, 3'b100, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 3'd0, 3'b101, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 3'd1, 3'b001, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 3'd0, 3'b101, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 3'd5, 3'b100, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 3'd4, 3'b110, 1'b0};

        // Reset state and table-driven step/decode sequence at DIV=0.
        en = 1'b1;
        dir = 1'b0;
        reset_dut(0, 0);
        chk("reset_q3", q3, 3'b101);
        chk("reset_step3", step3, 0);
        for (int i = 0; i < 10; i++) begin
            en = tbl[i].en;
            dir = tbl[i].dir;
            cyc();
            chk($sformatf("tbl%0d_step", i), step3, tbl[i].step);
            chk($sformatf("tbl%0d_q", i), q3, tbl[i].q);
            chk($sformatf("tbl%0d_sync", i), sync3, tbl[i].sync);
            chk($sformatf("tbl%0d_tick", i), tick3, 1);
        end

        // Reversal at step 4.
        dir = 1'b0;
        reset_dut(0, 0);
        repeat (4) cyc();
        chk("rev_start_step", step3, 4);
        dir = 1'b1;
        exp_rev = '{3, 2, 1, 0, 5};
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("rev%0d_step", i), step3, exp_rev[i]);
            chk($sformatf("rev%0d_sync", i), sync3, (exp_rev[i] == 0) ? 1 : 0);
        end

        // DIV=3: tick cadence, duty and sync rate.
        dir = 1'b0;
        reset_dut(3, 0);
        ticks = 0; syncs = 0; qhigh = 0; last_tick = -1; gap_bad = 0;
        for (int e = 1; e <= 48; e++) begin
            cyc();
            if (tick3) begin
                if (last_tick < 0) chk("div3_first_tick", e, 4);
                else if (e - last_tick != 4) gap_bad++;
                last_tick = e;
                ticks++;
            end
            if (sync3) syncs++;
            if (q3[0]) qhigh++;
        end
        chk("div3_ticks", ticks, 12);
        chk("div3_tick_gaps", gap_bad, 0);
        chk("div3_syncs", syncs, 2);
        chk("div3_q0_high", qhigh, 24);

        // DIV=9, DT=3: every drive is preceded by exactly 3 dead samples.
        reset_dut(9, 3);
        seen_drive = 0; gaps = 0; gap_len = 0;
        repeat (130) begin
            cyc();
            if (!h3[0] && !l3[0]) begin
                gap_len++;
            end else begin
                if (seen_drive && gap_len != 0) begin
                    chk("dt3_gap_len", gap_len, 3);
                    gaps++;
                end
                seen_drive = 1;
                gap_len = 0;
            end
        end
        chk("dt3_gap_seen", (gaps >= 3) ? 1 : 0, 1);

        // Hold mid-step, then the remaining prescale count completes exactly.
        reset_dut(9, 0);
        repeat (15) cyc();
        chk("hold_pre_step", step3, 1);
        en = 1'b0;
        repeat (20) begin
            cyc();
            chk("hold_step", step3, 1);
            chk("hold_q", q3, 3'b001);
        end
        en = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick3 && n < 20);
        chk("hold_resume_edges", n, 5);

        // PHASES=4: Q[1] is Q[0] delayed by two steps.
        reset_dut(0, 0);
        hist.delete();
        repeat (24) begin
            cyc();
            hist.push_back(q4);
            if (hist.size() > 2) begin
                chk("n4_q1_lag", q4[1], hist[0][0]);
                void'(hist.pop_front());
            end
        end

        // Reset pulsed during a dead interval.
        reset_dut(9, 3);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick3 && n < 20);
        chk("mid_dt_tick_edge", n, 10);
        cyc();
        chk("mid_dt_in_gap", {h3[2], l3[2]}, 2'b00);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_dt_rst_h", h3, 0);
        chk("mid_dt_rst_l", l3, 0);
        chk("mid_dt_rst_step", step3, 0);
        reset_dut(9, 3);
        n = 0;
        do begin
            cyc();
            n++;
        end while (h3 == 0 && l3 == 0 && n < 20);
        chk("mid_dt_release_edges", n, 4);

        // Randomized run/hold/direction against the model.
        for (int r = 0; r < 4; r++) begin
            int rd = $urandom_range(0, 7);
            reset_dut(rd, $urandom_range(0, rd + 2));
            repeat (250) begin
                en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) dir = ~dir;
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
